// File: rtl/hp_mul_result_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : hp_mul_result_queue_if
// Description : Handshake, result and counter bundle for hp_mul_result_queue.
//               The slave modport is the queue side. The master modport is the
//               side that drives the upstream producer and downstream consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface hp_mul_result_queue_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    localparam int c_LVL_W = $clog2(DEPTH) + 1;

    // upstream side
    logic               in_valid;
    logic               in_ready;
    logic [15:0]        in_product;
    logic [1:0]         in_ex_flag;
    // downstream side
    logic               out_valid;
    logic               out_ready;
    logic [15:0]        out_result;
    logic [1:0]         out_flag;
    // status / counters
    logic [c_LVL_W-1:0] level;
    logic               clear_counts;
    logic [CNT_W-1:0]   of_count;
    logic [CNT_W-1:0]   uf_count;
    logic [CNT_W-1:0]   nan_count;

    modport slave (
        input  in_valid, in_product, in_ex_flag, out_ready, clear_counts,
        output in_ready, out_valid, out_result, out_flag, level,
               of_count, uf_count, nan_count
    );

    modport master (
        output in_valid, in_product, in_ex_flag, out_ready, clear_counts,
        input  in_ready, out_valid, out_result, out_flag, level,
               of_count, uf_count, nan_count
    );
endinterface
`default_nettype wire

// File: rtl/hp_mul_result_queue.sv
`default_nettype none
// ============================================================================
// Module      : hp_mul_result_queue
// Description : Output queue for hp_multiplier results. It rewrites exception
//               results into canonical half-precision encodings at write time,
//               buffers DEPTH entries in a first-word-fall-through FIFO, and
//               keeps saturating per-class exception counters.
//               Macro HP_RQ_FIXUP_EN enables the exception fixup. When the
//               macro is undefined, products are stored unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module hp_mul_result_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    hp_mul_result_queue_if.slave   bus
);
    localparam int                  c_ADDR_W = $clog2(DEPTH);
    localparam int                  c_LVL_W  = c_ADDR_W + 1;
    localparam logic [c_LVL_W-1:0]  c_FULL   = c_LVL_W'(DEPTH);
    localparam logic [c_ADDR_W-1:0] c_PTR1   = c_ADDR_W'(1);
    localparam logic [CNT_W-1:0]    c_CNT1   = CNT_W'(1);

    logic [17:0]         r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0]  r_level;
    logic [CNT_W-1:0]    r_of_cnt;
    logic [CNT_W-1:0]    r_uf_cnt;
    logic [CNT_W-1:0]    r_nan_cnt;

    logic                w_in_ready;
    logic                w_out_valid;
    logic                w_push;
    logic                w_pop;
    logic [15:0]         w_fixed;
    logic [17:0]         w_head;

    // in_ready is derived from state and reset only, never from out_ready
    assign w_in_ready  = !rst && (r_level != c_FULL);
    assign w_out_valid = (r_level != '0);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;
    assign w_head      = r_mem[r_rd_ptr];

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_result = w_out_valid ? w_head[15:0]  : 16'h0000;
    assign bus.out_flag   = w_out_valid ? w_head[17:16] : 2'b00;
    assign bus.level      = r_level;
    assign bus.of_count   = r_of_cnt;
    assign bus.uf_count   = r_uf_cnt;
    assign bus.nan_count  = r_nan_cnt;

    // Rewrite exception products into canonical encodings before storage
    always_comb begin
        w_fixed = bus.in_product;
`ifdef HP_RQ_FIXUP_EN
        case (bus.in_ex_flag)
            2'b01:   w_fixed = {bus.in_product[15], 5'h1F, 10'h000};
            2'b10:   w_fixed = {bus.in_product[15], 15'h0000};
            2'b11:   w_fixed = 16'h7E00;
            default: w_fixed = bus.in_product;
        endcase
`endif
    end

    // Storage array. It has no reset because stale slots are never visible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.in_ex_flag, w_fixed};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR1;
        end
    end

    // Occupancy holds when a push and a pop happen in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Saturating exception counters. A clear overrides a same-cycle event.
    always_ff @(posedge clk) begin
        if (rst || bus.clear_counts) begin
            r_of_cnt  <= '0;
            r_uf_cnt  <= '0;
            r_nan_cnt <= '0;
        end else if (w_push) begin
            if (bus.in_ex_flag == 2'b01 && r_of_cnt != '1)
                r_of_cnt <= r_of_cnt + c_CNT1;
            if (bus.in_ex_flag == 2'b10 && r_uf_cnt != '1)
                r_uf_cnt <= r_uf_cnt + c_CNT1;
            if (bus.in_ex_flag == 2'b11 && r_nan_cnt != '1)
                r_nan_cnt <= r_nan_cnt + c_CNT1;
        end
    end
endmodule
`default_nettype wire

// File: doc/hp_mul_result_queue.md
# hp_mul_result_queue

Output stage that sits directly downstream of `hp_multiplier` and consumes its `hp_product` / `ex_flag` pair.
- Accepts one result per handshake.
- Rewrites exception results into canonical IEEE half-precision encodings: overflow → ±inf, underflow → ±0, special-input → quiet NaN.
- Buffers up to DEPTH results in a first-word-fall-through FIFO with a valid/ready output.
- Keeps saturating per-class exception counters for software/bench visibility.

## Interface
Parameters:
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `CNT_W`, 16, width of each exception counter.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `in_valid` in 1: upstream result present.
- `in_ready` out 1: queue can accept this cycle.
- `in_product` in 16: multiplier `hp_product` (`{s, exp[4:0], frac[9:0]}`).
- `in_ex_flag` in 2: multiplier `ex_flag`, encoded `{UF, OF}`:
  - 00 normal
  - 01 overflow
  - 10 underflow
  - 11 special input
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: downstream takes head this cycle.
- `out_result` out 16: fixed-up half-precision value at head.
- `out_flag` out 2: `ex_flag` stored with head entry; unchanged from input.
- `level` out $clog2(DEPTH)+1: current occupancy.
- `clear_counts` in 1: synchronous clear of all counters.
- `of_count` out CNT_W: overflow results accepted.
- `uf_count` out CNT_W: underflow results accepted.
- `nan_count` out CNT_W: special results accepted.

## Operation
- Push when `in_valid && in_ready`.
  - `in_ready = !rst && (level != DEPTH)`.
  - Purely from state; never depends on `out_ready`.
- Pop when `out_valid && out_ready`.
  - `out_valid = (level != 0)`.
- Fixup is applied at write time, using `s = in_product[15]`:
  - flag 00: store `in_product` unchanged.
  - flag 01: store `{s, 5'h1F, 10'h000}` (±inf).
  - flag 10: store `{s, 15'h0000}` (±0).
  - flag 11: store `16'h7E00` (quiet NaN, sign cleared).
- `out_result`/`out_flag` show the head entry combinationally from storage. Both are forced to 0 when `level == 0`.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. `level` tracks occupancy:
  - push only: +1.
  - pop only: −1.
  - push and pop in the same cycle: unchanged; both pointers advance.
- Full (`level == DEPTH`): `in_ready` = 0. A pop that cycle frees a slot, but `in_ready` rises only on the next cycle.
- Empty: pop impossible since `out_valid` = 0. A push sets `out_valid` next cycle.
- Counters:
  - Increment on push with the matching flag: 01 → `of_count`, 10 → `uf_count`, 11 → `nan_count`.
  - Saturate at all-ones; no wrap.
  - `clear_counts` zeroes all three. If an increment and `clear_counts` land in the same cycle, clear wins and the event is not counted.
  - Counters are independent of pops.

## Timing
- Reset (`rst` = 1 at a clock edge):
  - pointers = 0, `level` = 0, all counters = 0.
  - `out_valid` = 0, `out_result` = 0, `out_flag` = 0.
  - `in_ready` = 0 while `rst` is high and 1 in the first cycle after.
  - Stored contents are discarded.
- Reset mid-operation: all queued entries are dropped. A push presented in the reset cycle is ignored.
- Latency: a push at edge N appears on `out_result` after edge N (visible in cycle N+1).
- Throughput: one push and one pop per cycle sustained when `0 < level < DEPTH`.
- No combinational path from `in_*` to `out_*`. No path from `out_ready` to `in_ready`.

## Configuration
- Macro `HP_RQ_FIXUP_EN`.
  - Defined: exception fixup exactly as in Operation.
  - Undefined: `in_product` is stored unchanged for every flag value. `out_flag` and the counters behave identically, and downstream logic must interpret `out_flag` itself.

## Test plan
- **Reset/idle:** assert `rst` 2 cycles with `in_valid` = 1 → `level` = 0, `out_valid` = 0, counters 0; `in_ready` = 1 the first cycle after release.
- **Fixup (macro defined):** push, one per cycle:
  - `0x3C00`/00 → `0x3C00`
  - `0xD555`/01 → `0xFC00`
  - `0x8123`/10 → `0x8000`
  - `0x7D55`/11 → `0x7E00`
  - Expect: counters end at of=1, uf=1, nan=1, and results pop in order.
- **Full/backpressure:** `out_ready` = 0, push 5 distinct values with DEPTH = 4 → `level` = 4, `in_ready` = 0, 5th not accepted. Raise `out_ready` → the first 4 values drain in order.
- **Simultaneous push/pop:** from `level` = 2, push and pop in the same cycle → `level` stays 2, head advances. Repeat 8 cycles to exercise pointer wrap with no reordering.
- **Counter saturation/clear:** with `CNT_W` = 2, push 5 overflow results → `of_count` = 3. Assert `clear_counts` in the same cycle as a 6th overflow push → `of_count` = 0.
- **Macro undefined:** push `0x7D55`/11 → `out_result` = `0x7D55`, `out_flag` = 11, `nan_count` = 1.
